coms_motor_responder: RTL

//  Motor-board end of the RS485 motor bus: responder to the FPGA bus master that sends status requests,

---
 rtl/coms_motor_responder.sv | 388 ++++++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/coms_motor_responder.sv
// Motor-board RS485 responder: decodes addressed, CRC-checked master frames into latched motor
// parameters and answers status requests with a status frame over a half-duplex UART.

module uart_rx #(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int BAUDRATE    = 2_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid
);
  localparam int CPB = CLK_FREQ_HZ / BAUDRATE;
  localparam int CW = $clog2(CPB + 1);
  localparam logic [CW-1:0] FULL = CW'(CPB - 1);
  localparam logic [CW-1:0] HALF = CW'(CPB / 2 - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t     state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [7:0]    shreg, shreg_n, data_n;
  logic          valid_n;
  logic [1:0]    sync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync    <= 2'b11;
      state   <= RX_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      data    <= '0;
      valid   <= 1'b0;
    end else begin
      sync    <= {sync[0], rx};
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_idx_n;
      shreg   <= shreg_n;
      data    <= data_n;
      valid   <= valid_n;
    end
  end

  // Bits are sampled mid-cell; a low stop bit drops the byte as a framing error.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    data_n    = data;
    valid_n   = 1'b0;
    case (state)
      RX_IDLE: if (!sync[1]) begin
        cnt_n   = '0;
        state_n = RX_START;
      end
      RX_START: if (cnt == HALF) begin
        cnt_n     = '0;
        bit_idx_n = '0;
        state_n   = sync[1] ? RX_IDLE : RX_DATA;
      end else cnt_n = cnt + 1'b1;
      RX_DATA: if (cnt == FULL) begin
        cnt_n   = '0;
        shreg_n = {sync[1], shreg[7:1]};
        if (bit_idx == 3'd7) state_n = RX_STOP;
        else bit_idx_n = bit_idx + 1'b1;
      end else cnt_n = cnt + 1'b1;
      RX_STOP: if (cnt == FULL) begin
        if (sync[1]) begin
          data_n  = shreg;
          valid_n = 1'b1;
        end
        state_n = RX_IDLE;
      end else cnt_n = cnt + 1'b1;
      default: state_n = RX_IDLE;
    endcase
  end
endmodule

module uart_tx #(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int BAUDRATE    = 2_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       active
);
  localparam int CPB = CLK_FREQ_HZ / BAUDRATE;
  localparam int CW = $clog2(CPB + 1);
  localparam logic [CW-1:0] FULL = CW'(CPB - 1);

  typedef enum logic {TX_IDLE, TX_BITS} tx_state_t;

  tx_state_t     state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0]    bit_idx, bit_idx_n;
  logic [9:0]    shreg, shreg_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= TX_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '1;
      tx      <= 1'b1;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_idx_n;
      shreg   <= shreg_n;
      tx      <= (state_n == TX_BITS) ? shreg_n[0] : 1'b1;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    case (state)
      TX_IDLE: if (start) begin
        shreg_n   = {1'b1, data, 1'b0};
        cnt_n     = '0;
        bit_idx_n = '0;
        state_n   = TX_BITS;
      end
      TX_BITS: if (cnt == FULL) begin
        cnt_n   = '0;
        shreg_n = {1'b1, shreg[9:1]};
        if (bit_idx == 4'd9) state_n = TX_IDLE;
        else bit_idx_n = bit_idx + 1'b1;
      end else cnt_n = cnt + 1'b1;
      default: state_n = TX_IDLE;
    endcase
  end

  assign active = (state == TX_BITS);
endmodule

module coms_motor_responder #(
  parameter int MOTOR_ID          = 0,
  parameter int CLK_FREQ_HZ       = 50_000_000,
  parameter int BAUDRATE          = 2_000_000,
  parameter int RX_TIMEOUT_CYCLES = 1000,
  parameter int TURNAROUND_CYCLES = 50
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rx_i,
  output logic               tx_o,
  output logic               tx_enable,
  input  logic signed [23:0] encoder0_position,
  input  logic signed [23:0] encoder1_position,
  input  logic signed [23:0] duty,
  input  logic signed [23:0] displacement,
  output logic        [7:0]  control_mode,
  output logic signed [7:0]  Kp,
  output logic signed [7:0]  Ki,
  output logic signed [7:0]  Kd,
  output logic signed [23:0] PWMLimit,
  output logic signed [23:0] IntegralLimit,
  output logic signed [23:0] deadband,
  output logic signed [23:0] setpoint,
  output logic signed [23:0] gearboxRatio,
  output logic               control_mode_update,
  output logic               setpoint_update,
  output logic        [15:0] crc_error_count
);
  localparam int PAYLOAD_MAX = 22;
  localparam int REPLY_LEN   = 23;
  localparam int TO_W = $clog2(RX_TIMEOUT_CYCLES + 1);
  localparam int TA_W = $clog2(TURNAROUND_CYCLES + 1);
  localparam logic [TO_W-1:0] TIMEOUT  = TO_W'(RX_TIMEOUT_CYCLES);
  localparam logic [TA_W-1:0] TA_LAST  = TA_W'(TURNAROUND_CYCLES - 1);
  localparam logic [4:0]      LAST_IDX = 5'(REPLY_LEN - 1);
  localparam logic [7:0]      ID8      = 8'(MOTOR_ID);
  localparam logic [31:0] MAGIC_REQ = 32'h1CE1_CEBB;
  localparam logic [31:0] MAGIC_SP  = 32'hD0D0_D0D0;
  localparam logic [31:0] MAGIC_CM  = 32'hBAAD_A555;

  typedef enum logic [2:0] {
    S_HUNT, S_RECEIVE, S_CHECK, S_TURNAROUND, S_PREPARE, S_GEN_CRC, S_SEND
  } state_t;
  typedef enum logic [1:0] {F_STATUS, F_SETPOINT, F_CONTROL} frame_t;

  state_t          state, state_n;
  frame_t          ftype, hit_type;
  logic [31:0]     magic_sr, magic_next;
  logic            magic_hit;
  logic [7:0]      payload [0:PAYLOAD_MAX-1];
  logic [7:0]      txbuf [0:REPLY_LEN-1];
  logic [4:0]      byte_cnt, plen, tx_idx;
  logic [TO_W-1:0] idle_cnt;
  logic [TA_W-1:0] ta_cnt;
  logic [15:0]     crc_acc, crc_rx, crc_tx;
  logic            crc_ok, id_ok;
  logic [7:0]      rx_data, tx_data;
  logic            rx_valid, tx_start, tx_active, tx_active_q, tx_fall;
  logic [23:0]     cm_setpoint;

  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int b = 7; b >= 0; b--) begin
      if (r[15] ^ d[b]) r = {r[14:0], 1'b0} ^ 16'h8005;
      else r = {r[14:0], 1'b0};
    end
    return r;
  endfunction

  uart_rx #(.CLK_FREQ_HZ(CLK_FREQ_HZ), .BAUDRATE(BAUDRATE)) u_rx (
    .clk(clk), .reset(reset), .rx(rx_i), .data(rx_data), .valid(rx_valid)
  );

  uart_tx #(.CLK_FREQ_HZ(CLK_FREQ_HZ), .BAUDRATE(BAUDRATE)) u_tx (
    .clk(clk), .reset(reset), .start(tx_start), .data(tx_data), .tx(tx_o), .active(tx_active)
  );

  assign tx_enable   = tx_active;
  assign tx_fall     = tx_active_q & ~tx_active;
  assign magic_next  = {magic_sr[23:0], rx_data};
  assign crc_rx      = {payload[plen - 5'd2], payload[plen - 5'd1]};
  assign crc_ok      = (crc_acc == crc_rx);
  assign id_ok       = (payload[0] == ID8);
  assign cm_setpoint = {payload[14], payload[15], payload[16]};

  always_comb begin
    magic_hit = 1'b1;
    hit_type  = F_STATUS;
    case (magic_next)
      MAGIC_REQ: hit_type = F_STATUS;
      MAGIC_SP:  hit_type = F_SETPOINT;
      MAGIC_CM:  hit_type = F_CONTROL;
      default:   magic_hit = 1'b0;
    endcase
  end

  always_comb begin
    case (ftype)
      F_SETPOINT: plen = 5'd6;
      F_CONTROL:  plen = 5'd22;
      default:    plen = 5'd3;
    endcase
  end

  always_comb begin
    crc_tx = 16'hFFFF;
    for (int i = 4; i < REPLY_LEN - 2; i++) crc_tx = crc16_byte(crc_tx, txbuf[i]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_HUNT;
    else state <= state_n;
  end

  always_comb begin
    state_n  = state;
    tx_start = 1'b0;
    tx_data  = txbuf[0];
    case (state)
      S_HUNT: if (rx_valid && magic_hit) state_n = S_RECEIVE;
      S_RECEIVE: begin
        if (rx_valid) begin
          if (byte_cnt == plen - 5'd1) state_n = S_CHECK;
        end else if (idle_cnt == TIMEOUT) state_n = S_HUNT;
      end
      S_CHECK: state_n = (crc_ok && id_ok && ftype == F_STATUS) ? S_TURNAROUND : S_HUNT;
      S_TURNAROUND: if (ta_cnt == TA_LAST) state_n = S_PREPARE;
      S_PREPARE: state_n = S_GEN_CRC;
      S_GEN_CRC: begin
        tx_start = 1'b1;
        state_n  = S_SEND;
      end
      S_SEND: if (tx_fall) begin
        if (tx_idx == LAST_IDX) state_n = S_HUNT;
        else begin
          tx_start = 1'b1;
          tx_data  = txbuf[tx_idx + 5'd1];
        end
      end
      default: state_n = S_HUNT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      magic_sr            <= '0;
      ftype               <= F_STATUS;
      byte_cnt            <= '0;
      idle_cnt            <= '0;
      ta_cnt              <= '0;
      crc_acc             <= 16'hFFFF;
      tx_idx              <= '0;
      tx_active_q         <= 1'b0;
      for (int i = 0; i < PAYLOAD_MAX; i++) payload[i] <= '0;
      for (int i = 0; i < REPLY_LEN; i++) txbuf[i] <= '0;
      control_mode        <= '0;
      Kp                  <= '0;
      Ki                  <= '0;
      Kd                  <= '0;
      PWMLimit            <= '0;
      IntegralLimit       <= '0;
      deadband            <= '0;
      setpoint            <= '0;
      gearboxRatio        <= '0;
      control_mode_update <= 1'b0;
      setpoint_update     <= 1'b0;
      crc_error_count     <= '0;
    end else begin
      setpoint_update     <= 1'b0;
      control_mode_update <= 1'b0;
      tx_active_q         <= tx_active;
      // Bytes seen while not hunting (including our own reply) never seed a magic match.
      if (state != S_HUNT) magic_sr <= '0;
      if (state != S_TURNAROUND) ta_cnt <= '0;
      case (state)
        S_HUNT: if (rx_valid) begin
          magic_sr <= magic_next;
          if (magic_hit) begin
            ftype    <= hit_type;
            byte_cnt <= '0;
            idle_cnt <= '0;
            crc_acc  <= 16'hFFFF;
          end
        end
        S_RECEIVE: begin
          if (rx_valid) begin
            payload[byte_cnt] <= rx_data;
            byte_cnt          <= byte_cnt + 5'd1;
            idle_cnt          <= '0;
            if (byte_cnt < plen - 5'd2) crc_acc <= crc16_byte(crc_acc, rx_data);
          end else if (idle_cnt != TIMEOUT) idle_cnt <= idle_cnt + 1'b1;
        end
        S_CHECK: begin
          if (!crc_ok) begin
            if (crc_error_count != 16'hFFFF) crc_error_count <= crc_error_count + 16'd1;
          end else if (id_ok) begin
            if (ftype == F_SETPOINT) begin
              setpoint        <= {payload[1], payload[2], payload[3]};
              setpoint_update <= 1'b1;
            end else if (ftype == F_CONTROL) begin
              control_mode        <= payload[1];
              Kp                  <= payload[2];
              Ki                  <= payload[3];
              Kd                  <= payload[4];
              PWMLimit            <= {payload[5], payload[6], payload[7]};
              IntegralLimit       <= {payload[8], payload[9], payload[10]};
              deadband            <= {payload[11], payload[12], payload[13]};
              setpoint            <= cm_setpoint;
              gearboxRatio        <= {payload[17], payload[18], payload[19]};
              control_mode_update <= 1'b1;
              setpoint_update     <= (cm_setpoint != setpoint);
            end
          end
        end
        S_TURNAROUND: ta_cnt <= ta_cnt + 1'b1;
        S_PREPARE: begin
          // Reported setpoint is the latched value so the master can spot a lost setpoint frame.
          txbuf[0]  <= 8'h1C;
          txbuf[1]  <= 8'hEB;
          txbuf[2]  <= 8'h00;
          txbuf[3]  <= 8'hDA;
          txbuf[4]  <= ID8;
          txbuf[5]  <= control_mode;
          {txbuf[6], txbuf[7], txbuf[8]}    <= encoder0_position;
          {txbuf[9], txbuf[10], txbuf[11]}  <= encoder1_position;
          {txbuf[12], txbuf[13], txbuf[14]} <= setpoint;
          {txbuf[15], txbuf[16], txbuf[17]} <= duty;
          {txbuf[18], txbuf[19], txbuf[20]} <= displacement;
        end
        S_GEN_CRC: begin
          txbuf[21] <= crc_tx[15:8];
          txbuf[22] <= crc_tx[7:0];
          tx_idx    <= '0;
        end
        S_SEND: if (tx_fall && tx_idx != LAST_IDX) tx_idx <= tx_idx + 5'd1;
        default: ;
      endcase
    end
  end
endmodule
